// File: rtl/rf_port_arbiter_if.sv
// Handshake and register-file pin bundle for rf_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/file side.
interface rf_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  // Operand fetch request
  logic              req_valid;
  logic [ADDR_W-1:0] req_rs;
  logic [ADDR_W-1:0] req_rt;
  logic              req_ready;

  // Writeback request
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;

  // Register file pins
  logic              rf_rw;
  logic [ADDR_W-1:0] rf_rs;
  logic [ADDR_W-1:0] rf_rt;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;

  // Operand output stage
  logic              op_valid;
  logic [DATA_W-1:0] op_rs_data;
  logic [DATA_W-1:0] op_rt_data;
  logic              op_ready;

  modport slave (
    input  req_valid, req_rs, req_rt,
    input  wb_valid, wb_rd, wb_data,
    input  rf_rs_data, rf_rt_data,
    input  op_ready,
    output req_ready, wb_ready,
    output rf_rw, rf_rs, rf_rt, rf_rd, rf_rd_data,
    output op_valid, op_rs_data, op_rt_data
  );

  modport master (
    output req_valid, req_rs, req_rt,
    output wb_valid, wb_rd, wb_data,
    output rf_rs_data, rf_rt_data,
    output op_ready,
    input  req_ready, wb_ready,
    input  rf_rw, rf_rs, rf_rt, rf_rd, rf_rd_data,
    input  op_valid, op_rs_data, op_rt_data
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Arbitrates writeback vs operand fetch onto a single-port-write register file
// and registers the returned operand pair into a valid/ready output stage.
module rf_port_arbiter #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  rf_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_starve;
  logic              r_op_valid;
  logic [DATA_W-1:0] r_op_rs_data;
  logic [DATA_W-1:0] r_op_rt_data;

  logic              w_force_read;
  logic              w_wb_grant;
  logic              w_port_write;
  logic              w_read_elig;
  logic              w_read_grant;
  logic              w_op_release;

  logic              w_rf_rw;
  logic [ADDR_W-1:0] w_rf_rs;
  logic [ADDR_W-1:0] w_rf_rt;
  logic [ADDR_W-1:0] w_rf_rd;
  logic [DATA_W-1:0] w_rf_rd_data;

  assign w_force_read = (r_starve == 4'(STARVE_LIMIT));

  // A write to r0 never touches the file, so it can share a cycle with a read.
  assign w_wb_grant   = !reset && bus.wb_valid &&
                        ((bus.wb_rd == '0) || !w_force_read);
  assign w_port_write = w_wb_grant && (bus.wb_rd != '0);

  assign w_read_elig  = bus.req_valid &&
                        ((r_state == IDLE) || ((r_state == HOLD) && bus.op_ready));
  assign w_read_grant = !reset && w_read_elig && !w_port_write;

  assign w_op_release = (r_state == HOLD) && bus.op_ready && !w_read_grant;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_rf_rw      = 1'b0;
    w_rf_rs      = '0;
    w_rf_rt      = '0;
    w_rf_rd      = '0;
    w_rf_rd_data = '0;

    unique case (r_state)
      IDLE:    if (w_read_grant) w_state_next = WAIT;
      WAIT:    w_state_next = HOLD;
      HOLD:    if (bus.op_ready) w_state_next = w_read_grant ? WAIT : IDLE;
      default: w_state_next = IDLE;
    endcase

    if (w_port_write) begin
      w_rf_rw      = 1'b1;
      w_rf_rd      = bus.wb_rd;
      w_rf_rd_data = bus.wb_data;
    end

    if (w_read_grant) begin
      w_rf_rs = bus.req_rs;
      w_rf_rt = bus.req_rt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_read_grant) begin
      r_starve <= '0;
    end else if (w_read_elig && w_port_write && !w_force_read) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // File data is valid during WAIT; in HOLD the pair is frozen until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_valid   <= 1'b0;
      r_op_rs_data <= '0;
      r_op_rt_data <= '0;
    end else if (r_state == WAIT) begin
      r_op_valid   <= 1'b1;
      r_op_rs_data <= bus.rf_rs_data;
      r_op_rt_data <= bus.rf_rt_data;
    end else if (w_op_release) begin
      r_op_valid   <= 1'b0;
    end
  end

  assign bus.req_ready  = w_read_grant;
  assign bus.wb_ready   = w_wb_grant;
  assign bus.rf_rw      = w_rf_rw;
  assign bus.rf_rs      = w_rf_rs;
  assign bus.rf_rt      = w_rf_rt;
  assign bus.rf_rd      = w_rf_rd;
  assign bus.rf_rd_data = w_rf_rd_data;
  assign bus.op_valid   = r_op_valid;
  assign bus.op_rs_data = r_op_rs_data;
  assign bus.op_rt_data = r_op_rt_data;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: behavioural register file, shadow
// register contents and a timed scoreboard of expected operand pairs.
module tb_rf_port_arbiter;
  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 3;
  localparam int STARVE_LIMIT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_port_arbiter #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: registered reads, r0 reads zero, write blocks read.
  logic [DATA_W-1:0] f_mem [8];
  logic [DATA_W-1:0] f_rs_q, f_rt_q;
  always @(posedge clk) begin
    if (bus.rf_rw) begin
      if (bus.rf_rd != '0) f_mem[bus.rf_rd] <= bus.rf_rd_data;
    end else begin
      f_rs_q <= (bus.rf_rs == '0) ? '0 : f_mem[bus.rf_rs];
      f_rt_q <= (bus.rf_rt == '0) ? '0 : f_mem[bus.rf_rt];
    end
  end
  assign bus.rf_rs_data = f_rs_q;
  assign bus.rf_rt_data = f_rt_q;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
  } exp_t;

  exp_t              sb_q [$];
  logic [DATA_W-1:0] shadow [8];

  // Scoreboard: push on read grant, compare two edges later when the pair is due.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (bus.req_ready === 1'b1) begin
        checks++;
        if (bus.rf_rs !== bus.req_rs || bus.rf_rt !== bus.req_rt || bus.rf_rw !== 1'b0) begin
          failures++;
          $display("FAIL read_pins: got rs=%0d rt=%0d rw=%b expected rs=%0d rt=%0d rw=0",
                   bus.rf_rs, bus.rf_rt, bus.rf_rw, bus.req_rs, bus.req_rt);
        end
        sb_q.push_back('{cyc + 2, shadow[bus.req_rs], shadow[bus.req_rt]});
      end
      if (bus.wb_ready === 1'b1) begin
        checks++;
        if (bus.wb_rd != '0) begin
          if (bus.rf_rw !== 1'b1 || bus.rf_rd !== bus.wb_rd || bus.rf_rd_data !== bus.wb_data) begin
            failures++;
            $display("FAIL write_pins: got rw=%b rd=%0d data=%h expected rw=1 rd=%0d data=%h",
                     bus.rf_rw, bus.rf_rd, bus.rf_rd_data, bus.wb_rd, bus.wb_data);
          end
          shadow[bus.wb_rd] = bus.wb_data;
        end else if (bus.rf_rw !== 1'b0) begin
          failures++;
          $display("FAIL write_r0_pins: got rw=%b expected rw=0", bus.rf_rw);
        end
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        checks++;
        if (bus.op_valid !== 1'b1 || bus.op_rs_data !== sb_q[0].rs || bus.op_rt_data !== sb_q[0].rt) begin
          failures++;
          $display("FAIL sb_operands: got v=%b rs=%h rt=%h expected v=1 rs=%h rt=%h",
                   bus.op_valid, bus.op_rs_data, bus.op_rt_data, sb_q[0].rs, sb_q[0].rt);
        end
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    bus.wb_valid  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 3'd1;
    bus.wb_data   = 8'h77;
    bus.req_valid = 1'b1;
    bus.req_rs    = 3'd1;
    bus.req_rt    = 3'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (bus.wb_ready !== 1'b0 || bus.req_ready !== 1'b0 || bus.op_valid !== 1'b0 ||
          bus.rf_rw !== 1'b0 || bus.op_rs_data !== 8'h00 || bus.op_rt_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs: got wb_rdy=%b req_rdy=%b op_v=%b rw=%b ops=%h/%h expected all 0",
                 bus.wb_ready, bus.req_ready, bus.op_valid, bus.rf_rw, bus.op_rs_data, bus.op_rt_data);
      end
    end
    tick();
    reset        = 1'b0;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.op_valid !== 1'b0 || bus.rf_rw !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got req_rdy=%b op_v=%b rw=%b expected 1 0 0",
               bus.req_ready, bus.op_valid, bus.rf_rw);
    end
    tick();
    idle(4);
  endtask

  task automatic test_write_read();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 3'd3;
    bus.wb_data  = 8'hA5;
    @(negedge clk);
    checks++;
    if (bus.wb_ready !== 1'b1 || bus.rf_rw !== 1'b1) begin
      failures++;
      $display("FAIL write_grant: got wb_rdy=%b rw=%b expected 1 1", bus.wb_ready, bus.rf_rw);
    end
    tick();
    bus.wb_valid  = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_rs    = 3'd3;
    bus.req_rt    = 3'd0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL read_grant: got req_rdy=%b expected 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_not_valid: got op_v=%b expected 0", bus.op_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b1 || bus.op_rs_data !== 8'hA5 || bus.op_rt_data !== 8'h00) begin
      failures++;
      $display("FAIL write_read_ops: got v=%b rs=%h rt=%h expected v=1 rs=a5 rt=00",
               bus.op_valid, bus.op_rs_data, bus.op_rt_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_to_idle: got op_v=%b expected 0", bus.op_valid);
    end
    idle(2);
  endtask

  task automatic test_collision();
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 3'd5;
    bus.wb_data   = 8'h3C;
    bus.req_valid = 1'b1;
    bus.req_rs    = 3'd5;
    bus.req_rt    = 3'd3;
    @(negedge clk);
    checks++;
    if (bus.wb_ready !== 1'b1 || bus.req_ready !== 1'b0 || bus.rf_rw !== 1'b1) begin
      failures++;
      $display("FAIL collision_write_first: got wb_rdy=%b req_rdy=%b rw=%b expected 1 0 1",
               bus.wb_ready, bus.req_ready, bus.rf_rw);
    end
    tick();
    bus.wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL collision_read_next: got req_rdy=%b expected 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (bus.op_rs_data !== 8'h3C || bus.op_rt_data !== 8'hA5) begin
      failures++;
      $display("FAIL collision_ops: got rs=%h rt=%h expected rs=3c rt=a5", bus.op_rs_data, bus.op_rt_data);
    end
    idle(3);
  endtask

  task automatic test_starvation();
    logic [5:0] exp_wb;
    logic [5:0] exp_req;
    exp_wb  = 6'b101111;
    exp_req = 6'b010000;
    bus.req_valid = 1'b1;
    bus.req_rs    = 3'd1;
    bus.req_rt    = 3'd2;
    for (int i = 0; i < 6; i++) begin
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 3'(i + 1);
      bus.wb_data  = 8'(8'h10 + i);
      @(negedge clk);
      checks++;
      if (bus.wb_ready !== exp_wb[i] || bus.req_ready !== exp_req[i] || bus.rf_rw !== exp_wb[i]) begin
        failures++;
        $display("FAIL starve_cycle%0d: got wb_rdy=%b req_rdy=%b rw=%b expected %b %b %b",
                 i, bus.wb_ready, bus.req_ready, bus.rf_rw, exp_wb[i], exp_req[i], exp_wb[i]);
      end
      tick();
    end
    bus.wb_valid  = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b1 || bus.op_rs_data !== 8'h10 || bus.op_rt_data !== 8'h11) begin
      failures++;
      $display("FAIL starve_ops: got v=%b rs=%h rt=%h expected v=1 rs=10 rt=11",
               bus.op_valid, bus.op_rs_data, bus.op_rt_data);
    end
    idle(3);
  endtask

  task automatic test_rd0_write();
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 3'd0;
    bus.wb_data   = 8'hFF;
    bus.req_valid = 1'b1;
    bus.req_rs    = 3'd0;
    bus.req_rt    = 3'd4;
    @(negedge clk);
    checks++;
    if (bus.wb_ready !== 1'b1 || bus.req_ready !== 1'b1 || bus.rf_rw !== 1'b0) begin
      failures++;
      $display("FAIL rd0_both_granted: got wb_rdy=%b req_rdy=%b rw=%b expected 1 1 0",
               bus.wb_ready, bus.req_ready, bus.rf_rw);
    end
    tick();
    bus.wb_valid  = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (bus.op_rs_data !== 8'h00 || bus.op_rt_data !== 8'h13) begin
      failures++;
      $display("FAIL rd0_ops: got rs=%h rt=%h expected rs=00 rt=13", bus.op_rs_data, bus.op_rt_data);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    bus.op_ready  = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_rs    = 3'd3;
    bus.req_rt    = 3'd4;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_grant: got req_rdy=%b expected 1", bus.req_ready);
    end
    tick();
    bus.req_rs = 3'd6;
    bus.req_rt = 3'd1;
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0 || bus.op_valid !== 1'b1 ||
          bus.op_rs_data !== 8'h12 || bus.op_rt_data !== 8'h13) begin
        failures++;
        $display("FAIL bp_hold%0d: got req_rdy=%b v=%b rs=%h rt=%h expected 0 1 12 13",
                 i, bus.req_ready, bus.op_valid, bus.op_rs_data, bus.op_rt_data);
      end
      tick();
    end
    bus.op_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.op_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_grant: got req_rdy=%b v=%b expected 1 1", bus.req_ready, bus.op_valid);
    end
    tick();
    bus.req_rs = 3'd2;
    bus.req_rt = 3'd3;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.op_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_wait: got req_rdy=%b v=%b expected 0 1", bus.req_ready, bus.op_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.op_rs_data !== 8'h15 || bus.op_rt_data !== 8'h10) begin
      failures++;
      $display("FAIL bp_back_to_back: got req_rdy=%b rs=%h rt=%h expected 1 15 10",
               bus.req_ready, bus.op_rs_data, bus.op_rt_data);
    end
    tick();
    bus.req_valid = 1'b0;
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      f_mem[i]  = '0;
      shadow[i] = '0;
    end
    f_rs_q        = '0;
    f_rt_q        = '0;
    bus.req_valid = 1'b0;
    bus.req_rs    = '0;
    bus.req_rt    = '0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.op_ready  = 1'b1;

    test_reset();
    test_write_read();
    test_collision();
    test_starvation();
    test_rd0_write();
    test_back_to_back();

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
